cvp14_vec_mem_seq: RTL and testbench

- Vector memory access sequencer between the CVP14 core's vector load/store datapath and the single-port DRAM interface (Addr/RD/WR/DataIn/DataOut).
- On a Start pulse it performs VLEN strided word accesses. Loads are pipelined: one read is issued per cycle and returned after RD_LAT cycles.
- Loads return one element per cycle to the vector register file. Stores fetch one element per cycle from it.

---
 rtl/cvp14_vec_mem_seq.sv | 118 +++++++++++
 tb/tb_cvp14_vec_mem_seq.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cvp14_vec_mem_seq.sv
// CVP14 vector memory sequencer: VLEN strided word loads/stores
// over the single-port DRAM bus, with a pipelined load return path.
module cvp14_vec_mem_seq #(
  parameter int VLEN   = 16,
  parameter int RD_LAT = 1,
  parameter int IW     = 4
) (
  input  logic          Clk1,
  input  logic          Reset,
  input  logic          Start,
  input  logic          IsStore,
  input  logic [15:0]   BaseAddr,
  input  logic [15:0]   Stride,
  output logic          Busy,
  output logic          Done,
  output logic [IW-1:0] StIdx,
  input  logic [15:0]   StData,
  output logic          LdValid,
  output logic [IW-1:0] LdIdx,
  output logic [15:0]   LdData,
  output logic [15:0]   Addr,
  output logic          RD,
  output logic          WR,
  output logic [15:0]   MemOut,
  input  logic [15:0]   MemIn
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [RD_LAT-1:0] HEAD =
    RD_LAT'(1) << (RD_LAT - 1);

  state_t        state;
  state_t        state_nxt;
  logic          is_st;
  logic [15:0]   stride;
  logic [15:0]   cur_addr;
  logic [RD_LAT-1:0] vld;
  logic [IW-1:0] idx_sr [RD_LAT];

  logic take;
  logic last;
  logic drained;
  logic issue_rd;

  assign take     = (state == S_IDLE) && Start && !Busy;
  assign last     = StIdx == IW'(VLEN - 1);
  // only the oldest read may still be outstanding when leaving DRAIN
  assign drained  = (vld & ~HEAD) == '0;
  assign issue_rd = (state == S_ISSUE) && !is_st;
  assign LdData   = LdValid ? MemIn : '0;

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (take) state_nxt = S_ISSUE;
      S_ISSUE: if (last) state_nxt = is_st ? S_DONE : S_DRAIN;
      S_DRAIN: if (drained) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk1) begin
    if (!Reset) begin
      state    <= S_IDLE;
      is_st    <= 1'b0;
      stride   <= '0;
      cur_addr <= '0;
      vld      <= '0;
      for (int i = 0; i < RD_LAT; i++) idx_sr[i] <= '0;
      Busy     <= 1'b0;
      Done     <= 1'b0;
      StIdx    <= '0;
      LdValid  <= 1'b0;
      LdIdx    <= '0;
      Addr     <= '0;
      RD       <= 1'b0;
      WR       <= 1'b0;
      MemOut   <= '0;
    end else begin
      state <= state_nxt;
      Done  <= state == S_DONE;
      Addr  <= '0;
      RD    <= 1'b0;
      WR    <= 1'b0;
      if (Done) Busy <= 1'b0;
      if (take) begin
        Busy     <= 1'b1;
        is_st    <= IsStore;
        stride   <= Stride;
        cur_addr <= BaseAddr;
        StIdx    <= '0;
      end
      if (state == S_ISSUE) begin
        Addr     <= cur_addr;
        RD       <= !is_st;
        WR       <= is_st;
        if (is_st) MemOut <= StData;
        cur_addr <= cur_addr + stride;
        StIdx    <= StIdx + 1'b1;
      end
      for (int i = RD_LAT - 1; i > 0; i--) begin
        vld[i]    <= vld[i-1];
        idx_sr[i] <= idx_sr[i-1];
      end
      vld[0]    <= issue_rd;
      idx_sr[0] <= StIdx;
      LdValid   <= vld[RD_LAT-1];
      LdIdx     <= idx_sr[RD_LAT-1];
    end
  end

endmodule

// File: tb/tb_cvp14_vec_mem_seq.sv
// Bench for cvp14_vec_mem_seq: two instances (RD_LAT 1 and 3)
// against a DRAM model and a per-cycle expectation model.
module tb_cvp14_vec_mem_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        start_a;
  logic        start_b;
  logic        is_store;
  logic [15:0] base_addr;
  logic [15:0] stride;
  logic [15:0] sd_base;
  logic        dsel;

  logic        busy_a, done_a, ldv_a, rd_a, wr_a;
  logic [3:0]  stidx_a, ldidx_a;
  logic [15:0] stdata_a, lddata_a, addr_a, memout_a, memin_a;
  logic        busy_b, done_b, ldv_b, rd_b, wr_b;
  logic [3:0]  stidx_b, ldidx_b;
  logic [15:0] stdata_b, lddata_b, addr_b, memout_b, memin_b;

  assign stdata_a = sd_base + {12'h0, stidx_a};
  assign stdata_b = sd_base + {12'h0, stidx_b};

  cvp14_vec_mem_seq #(.VLEN(16), .RD_LAT(1), .IW(4)) u_a (
    .Clk1(clk), .Reset(reset), .Start(start_a),
    .IsStore(is_store), .BaseAddr(base_addr), .Stride(stride),
    .Busy(busy_a), .Done(done_a), .StIdx(stidx_a),
    .StData(stdata_a), .LdValid(ldv_a), .LdIdx(ldidx_a),
    .LdData(lddata_a), .Addr(addr_a), .RD(rd_a), .WR(wr_a),
    .MemOut(memout_a), .MemIn(memin_a)
  );

  cvp14_vec_mem_seq #(.VLEN(16), .RD_LAT(3), .IW(4)) u_b (
    .Clk1(clk), .Reset(reset), .Start(start_b),
    .IsStore(is_store), .BaseAddr(base_addr), .Stride(stride),
    .Busy(busy_b), .Done(done_b), .StIdx(stidx_b),
    .StData(stdata_b), .LdValid(ldv_b), .LdIdx(ldidx_b),
    .LdData(lddata_b), .Addr(addr_b), .RD(rd_b), .WR(wr_b),
    .MemOut(memout_b), .MemIn(memin_b)
  );

  // DRAM model shared by both instances
  logic [15:0] mem [65536];
  bit          mem_wr [65536];
  logic [15:0] line_a [1];
  logic [15:0] line_b [3];
  assign memin_a = line_a[0];
  assign memin_b = line_b[2];

  function automatic logic [15:0] init_pat(input logic [15:0] a);
    if (a >= 16'h0100 && a <= 16'h010F) return 16'hA000 + (a - 16'h0100);
    return a ^ 16'h5555;
  endfunction

  function automatic logic [15:0] mem_rd(input logic [15:0] a);
    return mem_wr[a] ? mem[a] : init_pat(a);
  endfunction

  always @(posedge clk) begin
    line_a[0] <= rd_a ? mem_rd(addr_a) : 16'hDEAD;
    line_b[2] <= line_b[1];
    line_b[1] <= line_b[0];
    line_b[0] <= rd_b ? mem_rd(addr_b) : 16'hDEAD;
    if (wr_a) begin
      mem[addr_a]    <= memout_a;
      mem_wr[addr_a] <= 1'b1;
    end
    if (wr_b) begin
      mem[addr_b]    <= memout_b;
      mem_wr[addr_b] <= 1'b1;
    end
  end

  // reference memory contents, updated from the store rules
  logic [15:0] ref_mem [65536];
  bit          ref_wr [65536];

  function automatic logic [15:0] ref_rd(input logic [15:0] a);
    return ref_wr[a] ? ref_mem[a] : init_pat(a);
  endfunction

  logic        o_busy, o_done, o_ldv, o_rd, o_wr;
  logic [3:0]  o_stidx, o_ldidx;
  logic [15:0] o_lddata, o_addr, o_memout;
  assign o_busy   = dsel ? busy_b   : busy_a;
  assign o_done   = dsel ? done_b   : done_a;
  assign o_ldv    = dsel ? ldv_b    : ldv_a;
  assign o_rd     = dsel ? rd_b     : rd_a;
  assign o_wr     = dsel ? wr_b     : wr_a;
  assign o_stidx  = dsel ? stidx_b  : stidx_a;
  assign o_ldidx  = dsel ? ldidx_b  : ldidx_a;
  assign o_lddata = dsel ? lddata_b : lddata_a;
  assign o_addr   = dsel ? addr_b   : addr_a;
  assign o_memout = dsel ? memout_b : memout_a;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input int k,
                     input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, k, act, exp);
    end
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, "_busy_a"},   0, 32'(busy_a),   32'd0);
    chk({nm, "_done_a"},   0, 32'(done_a),   32'd0);
    chk({nm, "_rd_a"},     0, 32'(rd_a),     32'd0);
    chk({nm, "_wr_a"},     0, 32'(wr_a),     32'd0);
    chk({nm, "_ldv_a"},    0, 32'(ldv_a),    32'd0);
    chk({nm, "_addr_a"},   0, 32'(addr_a),   32'd0);
    chk({nm, "_memout_a"}, 0, 32'(memout_a), 32'd0);
    chk({nm, "_stidx_a"},  0, 32'(stidx_a),  32'd0);
    chk({nm, "_ldidx_a"},  0, 32'(ldidx_a),  32'd0);
    chk({nm, "_lddata_a"}, 0, 32'(lddata_a), 32'd0);
    chk({nm, "_busy_b"},   0, 32'(busy_b),   32'd0);
    chk({nm, "_rd_b"},     0, 32'(rd_b),     32'd0);
    chk({nm, "_addr_b"},   0, 32'(addr_b),   32'd0);
    chk({nm, "_ldv_b"},    0, 32'(ldv_b),    32'd0);
  endtask

  typedef struct {
    bit          sel;
    bit          st;
    logic [15:0] base;
    logic [15:0] stride;
    logic [15:0] sd;
    int          done_k;
    logic [15:0] last;
    int          restart_k;
  } vec_t;

  // cycle 0 carries Start; cycle k is observed at the k-th following negedge
  task automatic run_op(input vec_t v);
    int lat;
    int a;
    int r;
    bit acc;
    bit ldv;
    logic [15:0] ea;
    logic [15:0] last_seen;
    lat = v.sel ? 3 : 1;
    last_seen = 16'h0;
    @(negedge clk);
    dsel = v.sel;
    sd_base = v.sd;
    is_store = v.st;
    base_addr = v.base;
    stride = v.stride;
    if (v.sel) start_b = 1'b1;
    else start_a = 1'b1;
    for (int k = 1; k <= v.done_k + 2; k++) begin
      @(negedge clk);
      start_a = 1'b0;
      start_b = 1'b0;
      base_addr = v.base;
      a = k - 2;
      acc = a >= 0 && a < 16;
      ea = acc ? v.base + 16'(a) * v.stride : 16'h0;
      chk("busy", k, 32'(o_busy), 32'(k <= v.done_k));
      chk("done", k, 32'(o_done), 32'(k == v.done_k));
      chk("rd", k, 32'(o_rd), 32'(acc && !v.st));
      chk("wr", k, 32'(o_wr), 32'(acc && v.st));
      chk("addr", k, 32'(o_addr), 32'(ea));
      if (acc && v.st)
        chk("memout", k, 32'(o_memout), 32'(v.sd + 16'(a)));
      if (v.st && k <= 16)
        chk("stidx", k, 32'(o_stidx), 32'(k - 1));
      r = k - 2 - lat;
      ldv = !v.st && r >= 0 && r < 16;
      chk("ldvalid", k, 32'(o_ldv), 32'(ldv));
      if (ldv) begin
        chk("ldidx", k, 32'(o_ldidx), 32'(r));
        chk("lddata", k, 32'(o_lddata),
            32'(ref_rd(v.base + 16'(r) * v.stride)));
      end
      if (k == 17) last_seen = o_addr;
      if (k == v.restart_k) begin
        base_addr = v.base ^ 16'h4000;
        if (v.sel) start_b = 1'b1;
        else start_a = 1'b1;
      end
    end
    chk("last_addr", 0, 32'(last_seen), 32'(v.last));
    if (v.st) begin
      for (int i = 0; i < 16; i++) begin
        ref_mem[v.base + 16'(i) * v.stride] = v.sd + 16'(i);
        ref_wr[v.base + 16'(i) * v.stride] = 1'b1;
      end
      for (int i = 0; i < 16; i++) begin
        ea = v.base + 16'(i) * v.stride;
        chk("mem", i, 32'(mem_rd(ea)), 32'(ref_rd(ea)));
      end
    end
  endtask

  initial begin
    vec_t tbl [7];
    vec_t v;
    tbl[0] = '{0, 0, 16'h0100, 16'h0001, 16'h0000, 19, 16'h010F, -1};
    tbl[1] = '{0, 1, 16'hFFFE, 16'h0001, 16'h5A00, 18, 16'h000D, -1};
    tbl[2] = '{1, 0, 16'h0200, 16'h0010, 16'h0000, 21, 16'h02F0, -1};
    tbl[3] = '{0, 1, 16'h0300, 16'h0000, 16'h7700, 18, 16'h0300, -1};
    tbl[4] = '{0, 0, 16'h0300, 16'h0000, 16'h0000, 19, 16'h0300, -1};
    tbl[5] = '{1, 0, 16'hFFF8, 16'h0002, 16'h0000, 21, 16'h0016, -1};
    tbl[6] = '{0, 0, 16'h0100, 16'h0001, 16'h0000, 19, 16'h010F, 5};

    reset = 1'b0;
    start_a = 1'b1;
    start_b = 1'b1;
    is_store = 1'b0;
    base_addr = 16'h1234;
    stride = 16'h0001;
    sd_base = 16'h0;
    dsel = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk_idle("reset");
    end
    reset = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    @(negedge clk);
    chk_idle("post_reset");

    for (int i = 0; i < 7; i++) run_op(tbl[i]);
    chk("wrap_fffe", 0, 32'(mem_rd(16'hFFFE)), 32'h5A00);
    chk("wrap_0000", 0, 32'(mem_rd(16'h0000)), 32'h5A02);
    chk("wrap_000d", 0, 32'(mem_rd(16'h000D)), 32'h5A0F);

    // reset in the middle of a load
    @(negedge clk);
    dsel = 1'b0;
    is_store = 1'b0;
    base_addr = 16'h0100;
    stride = 16'h0001;
    start_a = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      start_a = 1'b0;
      chk("mid_ldv", k, 32'(o_ldv), 32'(k >= 3));
      if (k == 7) reset = 1'b0;
    end
    @(negedge clk);
    chk("abort_busy", 8, 32'(o_busy), 32'd0);
    chk("abort_ldv", 8, 32'(o_ldv), 32'd0);
    chk("abort_rd", 8, 32'(o_rd), 32'd0);
    chk("abort_addr", 8, 32'(o_addr), 32'd0);
    reset = 1'b1;
    for (int k = 9; k < 33; k++) begin
      @(negedge clk);
      chk("abort_ldv", k, 32'(o_ldv), 32'd0);
      chk("abort_done", k, 32'(o_done), 32'd0);
      chk("abort_busy", k, 32'(o_busy), 32'd0);
    end
    run_op(tbl[0]);

    for (int j = 0; j < 10; j++) begin
      v.sel = 1'($urandom_range(0, 1));
      v.st = 1'($urandom_range(0, 1));
      v.base = 16'($urandom);
      v.stride = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
      v.sd = 16'($urandom);
      v.done_k = v.st ? 18 : (v.sel ? 21 : 19);
      v.last = v.base + 16'd15 * v.stride;
      v.restart_k = (j % 3 == 0) ? 6 : -1;
      run_op(v);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
